// File: rtl/tu_align_ctrl.sv
// Trigger-unit receive word aligner: slips the deserializer until rx_data matches
// the training word for MATCH_CNT consecutive cycles, then enables FIFO capture.
module tu_align_ctrl #(
    parameter int DATA_W     = 64,
    parameter int SLIP_MAX   = 64,
    parameter int SETTLE_CYC = 4,
    parameter int MATCH_CNT  = 8,
    parameter int CW         = $clog2(SLIP_MAX + 1)
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] train_pattern,
    input  logic [DATA_W-1:0] rx_data,
    output logic              bitslip,
    output logic              fifo_ena,
    output logic              busy,
    output logic              locked,
    output logic              fail,
    output logic [CW-1:0]     slip_count
);

    localparam int SW        = $clog2(SETTLE_CYC + 1);
    localparam int MW        = $clog2(MATCH_CNT + 1);
    localparam int VEC_W     = 16;
    localparam int NUM_LANES = (DATA_W + VEC_W - 1) / VEC_W;
    localparam int PAD_W     = NUM_LANES * VEC_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [MW-1:0]   match_q, match_d;
    logic [CW-1:0]   slip_d;

    // Word compare split into 16-bit lanes; padding bits are zero on both sides.
    logic [NUM_LANES-1:0][VEC_W-1:0] rx_lanes, pat_lanes;
    logic [NUM_LANES-1:0]            lane_eq;
    logic                            word_match;

    assign rx_lanes  = PAD_W'(rx_data);
    assign pat_lanes = PAD_W'(train_pattern);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign lane_eq[l] = (rx_lanes[l] == pat_lanes[l]);
    end

    assign word_match = &lane_eq;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        match_d  = match_q;
        slip_d   = slip_count;
        if (abort) begin
            // slip_count is kept so software can read how far the search got
            state_d  = S_IDLE;
            settle_d = '0;
            match_d  = '0;
        end else if (start) begin
            state_d  = S_SETTLE;
            settle_d = '0;
            match_d  = '0;
            slip_d   = '0;
        end else begin
            case (state_q)
                S_SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYC - 1)) begin
                        state_d  = S_CHECK;
                        settle_d = '0;
                        match_d  = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (word_match) begin
                        match_d = match_q + 1'b1;
                        if (match_q == MW'(MATCH_CNT - 1)) state_d = S_LOCKED;
                    end else if (slip_count < CW'(SLIP_MAX)) begin
                        state_d = S_SLIP;
                        match_d = '0;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
                S_SLIP: begin
                    if (slip_count != CW'(SLIP_MAX)) slip_d = slip_count + 1'b1;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are flopped from the next state so they carry no input-to-output path.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            match_q    <= '0;
            slip_count <= '0;
            bitslip    <= 1'b0;
            fifo_ena   <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            match_q    <= match_d;
            slip_count <= slip_d;
            bitslip    <= (state_d == S_SLIP);
            fifo_ena   <= (state_d == S_LOCKED);
            locked     <= (state_d == S_LOCKED);
            fail       <= (state_d == S_FAIL);
            busy       <= (state_d == S_SETTLE) || (state_d == S_CHECK) || (state_d == S_SLIP);
        end
    end

endmodule

// File: doc/tu_align_ctrl.md
Name: tu_align_ctrl

Overview:
- Word-alignment sequencer for the trigger-unit receive path. It runs ahead of the trigger FIFO.
- It issues bitslip pulses to the deserializer until the received 64-bit word equals a programmed training pattern for a set number of consecutive cycles.
- Once aligned, it asserts the FIFO capture enable, `fifo_ena`, which drives the FIFO's bitslip_ena input.
- It reports lock, fail and slip count to the AXI register bank.

Parameters:
- DATA_W, 64: width of received word and training pattern.
- SLIP_MAX, 64: maximum bitslip pulses before declaring failure (≥1).
- SETTLE_CYC, 4: wait cycles after reset-of-search or after each slip before comparing (≥1).
- MATCH_CNT, 8: consecutive matching words required for lock (≥1).
- CW, $clog2(SLIP_MAX+1): slip counter width (derived).

Ports:
- S_AXI_ACLK, input, 1: sole clock; all logic on its rising edge.
- S_AXI_ARESETN, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse; begins or restarts an alignment search.
- abort, input, 1: level; forces IDLE and deasserts fifo_ena.
- train_pattern, input, DATA_W: expected training word (static during search).
- rx_data, input, DATA_W: deserialized word from the receiver.
- bitslip, output, 1: one-cycle slip pulse to the deserializer.
- fifo_ena, output, 1: capture enable to the trigger FIFO; high only in LOCKED.
- busy, output, 1: high in SETTLE, CHECK and SLIP.
- locked, output, 1: high in LOCKED.
- fail, output, 1: high in FAIL.
- slip_count, output, CW: slips issued in the current or last search.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0; slip_count, settle counter and match counter are 0.
- All outputs are registered and decoded from the state/counters; no combinational path from inputs to outputs.
- Priority each cycle: abort > start > state logic.
  - abort=1: next state IDLE and counters cleared. slip_count holds its value so it can be read back.
  - start=1 (abort=0), from any state: slip_count=0, match=0, settle=0, next state SETTLE. A start during LOCKED drops fifo_ena the next cycle.
- IDLE: wait for start.
- SETTLE:
  - settle counter increments each cycle.
  - When it reaches SETTLE_CYC-1, go to CHECK with match=0.
  - bitslip=0.
- CHECK: compare rx_data == train_pattern (full DATA_W, exact).
  - Match: match+1. When the count reaches MATCH_CNT (i.e. match==MATCH_CNT-1 and matching), go to LOCKED.
  - Mismatch, slip_count < SLIP_MAX: go to SLIP and clear match.
  - Mismatch, slip_count == SLIP_MAX: go to FAIL.
  - A mismatch after partial matches restarts counting only after a slip; there is no re-check without a slip.
- SLIP:
  - bitslip=1 for exactly this one cycle.
  - slip_count increments, saturating at SLIP_MAX.
  - settle counter cleared; next state SETTLE.
- LOCKED:
  - fifo_ena=1 and locked=1.
  - rx_data is ignored; the state is held until abort or start.
- FAIL: fail=1 and fifo_ena=0; held until abort or start.
- Timing:
  - bitslip pulses are separated by at least SETTLE_CYC+2 cycles.
  - bitslip is never asserted in two consecutive cycles.
  - Best-case lock latency: SETTLE_CYC+MATCH_CNT cycles from the cycle after the start pulse; locked rises the cycle after the final match.
  - Zero slips: if rx_data matches immediately, slip_count stays 0.
- Reset asserted mid-search or while LOCKED: outputs clear immediately (asynchronously). fifo_ena falls without waiting for a clock edge.
- Boundary cases:
  - train_pattern = 0 is legal; an all-zero rx_data then locks.
  - slip_count never exceeds SLIP_MAX.

Test Plan:
1. Reset, then start with rx_data==train_pattern=64'hA5A5_F0F0_1234_5678, SETTLE_CYC=4, MATCH_CNT=8 -> locked and fifo_ena rise 13 cycles after start; slip_count=0; bitslip never pulses.
2. Deserializer model needing 5 slips -> exactly 5 single-cycle bitslip pulses, each ≥6 cycles apart; then locked=1 and slip_count=5.
3. Pattern never matches, SLIP_MAX=64 -> 64 pulses, then fail=1, fifo_ena=0, slip_count=64; a following start clears fail and restarts with slip_count=0.
4. 7 matches then 1 mismatch then steady match -> one bitslip after the mismatch; lock only after 8 further consecutive matches.
5. abort asserted while LOCKED, and separately start and abort in the same cycle -> next cycle IDLE, fifo_ena=0, locked=0, slip_count retained.
6. S_AXI_ARESETN driven low between clock edges during SLIP -> bitslip, fifo_ena, busy and slip_count go to 0 immediately; after release the block stays IDLE until start.
